// File: rtl/new_means_calculation_block_pkg.sv
// Shared k-means widths: coordinate, accumulator and counter sizes.
// Every k-means block imports these so the packed formats stay consistent.
package new_means_calculation_block_pkg;

  localparam int accum_cord_w = 22;  // one accumulated coordinate, signed
  localparam int cord_w       = 13;  // one centroid coordinate, signed
  localparam int count_w      = 10;  // points assigned to a centroid, unsigned
  localparam int coord_num    = 7;   // coordinates per point
  localparam int centroid_cnt = 8;   // centroids tracked by the system

endpackage

// File: rtl/new_means_calculation_block_means_coord_divider.sv
// Combinational divide of one signed accumulated coordinate by an unsigned
// point count, saturated to the signed centroid coordinate range.
module means_coord_divider
  import new_means_calculation_block_pkg::*;
#(
  parameter int tc_mode        = 1,
  parameter int rem_mode       = 1,
  parameter int dividend_width = accum_cord_w,
  parameter int count_width    = count_w,
  parameter int quotient_width = cord_w
) (
  input  logic [dividend_width-1:0] dividend,
  input  logic [count_width-1:0]    count,
  output logic [quotient_width-1:0] quotient
);

  // One guard bit so a zero-extended count and the most negative dividend both fit.
  localparam int dw = dividend_width + 1;
  localparam logic signed [dw-1:0] q_max = dw'((2 ** (quotient_width - 1)) - 1);
  localparam logic signed [dw-1:0] q_min = ~q_max;

  logic signed [dw-1:0] dvd;
  logic signed [dw-1:0] dvs;
  logic signed [dw-1:0] q_raw;
  logic signed [dw-1:0] r_raw;
  logic signed [dw-1:0] q_adj;

  // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    dvd = (tc_mode != 0) ? {dividend[dividend_width-1], dividend} : {1'b0, dividend};
    dvs = '0;
    // A zero count is flagged by the top; divide by one to keep the datapath defined.
    dvs[count_width-1:0] = (count == '0) ? count_width'(1) : count;

    // Signed division truncates toward zero; floor mode adjusts negative remainders.
    q_raw = dvd / dvs;
    r_raw = dvd % dvs;
    q_adj = q_raw;
    if (rem_mode == 0 && r_raw[dw-1]) q_adj = q_raw - dw'(1);

    if (q_adj > q_max)      quotient = q_max[quotient_width-1:0];
    else if (q_adj < q_min) quotient = q_min[quotient_width-1:0];
    else                    quotient = q_adj[quotient_width-1:0];
  end

endmodule

// File: rtl/new_means_calculation_block.sv
// New-centroid computation: selects one centroid's coordinate sums and point
// count, divides all seven coordinates in parallel and registers the mean.
module new_means_calculation_block
  import new_means_calculation_block_pkg::*;
#(
  parameter int tc_mode          = 1,
  parameter int rem_mode         = 1,
  parameter int accum_width      = 154,
  parameter int addrWidth        = 8,
  parameter int dataWidth        = 91,
  parameter int centroid_num     = centroid_cnt,
  parameter int accum_cord_width = accum_cord_w,
  parameter int cordinate_width  = cord_w,
  parameter int count_width      = count_w
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [accum_width-1:0] accum_1,
  input  logic [accum_width-1:0] accum_2,
  input  logic [accum_width-1:0] accum_3,
  input  logic [accum_width-1:0] accum_4,
  input  logic [accum_width-1:0] accum_5,
  input  logic [accum_width-1:0] accum_6,
  input  logic [accum_width-1:0] accum_7,
  input  logic [accum_width-1:0] accum_8,
  input  logic [count_width-1:0] cnt_1,
  input  logic [count_width-1:0] cnt_2,
  input  logic [count_width-1:0] cnt_3,
  input  logic [count_width-1:0] cnt_4,
  input  logic [count_width-1:0] cnt_5,
  input  logic [count_width-1:0] cnt_6,
  input  logic [count_width-1:0] cnt_7,
  input  logic [count_width-1:0] cnt_8,
  input  logic [2:0]             cent_cnt,
  input  logic                   divider_en,
  output logic                   divide_by_0,
  output logic [dataWidth-1:0]   new_centroid
);

  // The port list is fixed at eight centroids of seven coordinates; reject other shapes.
  if (centroid_num != 8 || addrWidth < 1 ||
      accum_width != coord_num * accum_cord_width ||
      dataWidth != coord_num * cordinate_width) begin : g_param_check
    $error("new_means_calculation_block: inconsistent width parameters");
  end

  logic [accum_width-1:0] accum_sel;
  logic [count_width-1:0] cnt_sel;
  logic [dataWidth-1:0]   centroid_next;

  always_comb begin
    accum_sel = '0;
    cnt_sel   = '0;
    case (cent_cnt)
      3'd0: begin accum_sel = accum_1; cnt_sel = cnt_1; end
      3'd1: begin accum_sel = accum_2; cnt_sel = cnt_2; end
      3'd2: begin accum_sel = accum_3; cnt_sel = cnt_3; end
      3'd3: begin accum_sel = accum_4; cnt_sel = cnt_4; end
      3'd4: begin accum_sel = accum_5; cnt_sel = cnt_5; end
      3'd5: begin accum_sel = accum_6; cnt_sel = cnt_6; end
      3'd6: begin accum_sel = accum_7; cnt_sel = cnt_7; end
      default: begin accum_sel = accum_8; cnt_sel = cnt_8; end
    endcase
  end

  for (genvar k = 0; k < coord_num; k++) begin : g_div
    means_coord_divider #(
      .tc_mode       (tc_mode),
      .rem_mode      (rem_mode),
      .dividend_width(accum_cord_width),
      .count_width   (count_width),
      .quotient_width(cordinate_width)
    ) u_div (
      .dividend(accum_sel[k*accum_cord_width +: accum_cord_width]),
      .count   (cnt_sel),
      .quotient(centroid_next[k*cordinate_width +: cordinate_width])
    );
  end

  // NOTE: registered state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      new_centroid <= '0;
      divide_by_0  <= 1'b0;
    end else begin
      divide_by_0 <= 1'b0;
      if (divider_en) begin
        // A zero count keeps the previous mean and raises a one-cycle flag.
        if (cnt_sel == '0) divide_by_0  <= 1'b1;
        else               new_centroid <= centroid_next;
      end
    end
  end

endmodule

// File: tb/tb_new_means_calculation_block.sv
// Scoreboard bench for new_means_calculation_block: stimulus pushes hand-computed
// means, a monitor pops and compares one cycle after each accepted strobe.
module tb_new_means_calculation_block;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [153:0] accum_1, accum_2, accum_3, accum_4, accum_5, accum_6, accum_7, accum_8;
  logic [9:0]   cnt_1, cnt_2, cnt_3, cnt_4, cnt_5, cnt_6, cnt_7, cnt_8;
  logic [2:0]   cent_cnt;
  logic         divider_en;
  logic         divide_by_0;
  logic [90:0]  new_centroid;

  typedef struct packed {
    logic [90:0] c;
    logic        z;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  new_means_calculation_block dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .accum_1     (accum_1),
    .accum_2     (accum_2),
    .accum_3     (accum_3),
    .accum_4     (accum_4),
    .accum_5     (accum_5),
    .accum_6     (accum_6),
    .accum_7     (accum_7),
    .accum_8     (accum_8),
    .cnt_1       (cnt_1),
    .cnt_2       (cnt_2),
    .cnt_3       (cnt_3),
    .cnt_4       (cnt_4),
    .cnt_5       (cnt_5),
    .cnt_6       (cnt_6),
    .cnt_7       (cnt_7),
    .cnt_8       (cnt_8),
    .cent_cnt    (cent_cnt),
    .divider_en  (divider_en),
    .divide_by_0 (divide_by_0),
    .new_centroid(new_centroid)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [153:0] pk(input int c0, input int c1 = 0, input int c2 = 0,
                                      input int c3 = 0, input int c4 = 0, input int c5 = 0,
                                      input int c6 = 0);
    return {22'(c6), 22'(c5), 22'(c4), 22'(c3), 22'(c2), 22'(c1), 22'(c0)};
  endfunction

  function automatic logic [90:0] pc(input int q0, input int q1 = 0, input int q2 = 0,
                                     input int q3 = 0, input int q4 = 0, input int q5 = 0,
                                     input int q6 = 0);
    return {13'(q6), 13'(q5), 13'(q4), 13'(q3), 13'(q2), 13'(q1), 13'(q0)};
  endfunction

  task automatic strobe(input logic [2:0] sel, input logic [90:0] exp_c, input logic exp_z);
    @(negedge clk);
    cent_cnt   = sel;
    divider_en = 1'b1;
    sb.push_back('{c: exp_c, z: exp_z});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      divider_en = 1'b0;
    end
  endtask

  // Monitor: a strobe seen at a rising edge produces an output that is checked
  // just after the following falling edge; other cycles must hold the last mean.
  initial begin : monitor
    logic        pend;
    exp_t        e;
    logic [90:0] last;
    last = '0;
    forever begin
      @(posedge clk);
      pend = divider_en && rst_n;
      @(negedge clk);
      #1;
      if (!rst_n) begin
        last = '0;
      end else if (pend) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 128'd1, 128'd0);
        end else begin
          e = sb.pop_front();
          check("centroid", 128'(new_centroid), 128'(e.c));
          check("divide_by_0", 128'(divide_by_0), 128'(e.z));
          last = e.c;
        end
      end else begin
        check("hold_centroid", 128'(new_centroid), 128'(last));
        check("idle_divide_by_0", 128'(divide_by_0), 128'd0);
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    rst_n      = 1'b0;
    divider_en = 1'b0;
    cent_cnt   = 3'd0;
    accum_1 = pk(3584);                        cnt_1 = 10'd2;
    accum_2 = pk(1536);                        cnt_2 = 10'd3;
    accum_3 = pk(1693);                        cnt_3 = 10'd13;
    accum_4 = pk(-1528, 0, -907);              cnt_4 = 10'd11;
    accum_5 = pk(100, 200);                    cnt_5 = 10'd0;
    accum_6 = pk(1 << 20, -5);                 cnt_6 = 10'd1;
    accum_7 = pk(-(1 << 20), 0, 0, 0, 0, 0, 7); cnt_7 = 10'd1;
    accum_8 = pk(-2097152, 0, 0, 0, 0, 0, 2097151); cnt_8 = 10'd1023;

    #3;
    check("reset_centroid", 128'(new_centroid), 128'd0);
    check("reset_divide_by_0", 128'(divide_by_0), 128'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    idle(2);

    strobe(3'd2, pc(130), 1'b0);
    idle(2);
    strobe(3'd3, pc(-138, 0, -82), 1'b0);
    // Back-to-back strobes, then a zero count that must keep the previous mean.
    strobe(3'd0, pc(1792), 1'b0);
    strobe(3'd1, pc(512), 1'b0);
    strobe(3'd4, pc(512), 1'b1);
    idle(2);
    // Saturation at both ends and the widest divisor.
    strobe(3'd5, pc(4095, -5), 1'b0);
    strobe(3'd6, pc(-4096, 0, 0, 0, 0, 0, 7), 1'b0);
    strobe(3'd7, pc(-2050, 0, 0, 0, 0, 0, 2050), 1'b0);
    idle(2);

    // Reset lands between a strobe and its clock edge: no result may appear.
    @(negedge clk);
    cent_cnt   = 3'd2;
    divider_en = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("midreset_centroid", 128'(new_centroid), 128'd0);
    check("midreset_divide_by_0", 128'(divide_by_0), 128'd0);
    divider_en = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    idle(2);
    strobe(3'd0, pc(1792), 1'b0);
    idle(3);

    check("sb_drained", 128'(sb.size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
